// File: rtl/mac_array_ctrl.sv
// Sequencer for a ROW x COL weight-stationary systolic MAC array: kernel load,
// activation stream, psum drain, with per-row skewed instruction lanes.
module mac_array_ctrl #(
  parameter int unsigned ROW     = 8,
  parameter int unsigned COL     = 8,
  parameter int unsigned LEN_BW  = 8,
  parameter int unsigned ADDR_BW = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LEN_BW-1:0]  exec_len,
  output logic               busy,
  output logic               done,
  output logic               mem_rd_en,
  output logic               mem_sel,
  output logic [ADDR_BW-1:0] mem_addr,
  output logic [2*ROW-1:0]   inst_w
);

  localparam int unsigned SPAN_BW = $clog2(ROW + COL);
  localparam int unsigned CNT_BW  = ((LEN_BW > SPAN_BW) ? LEN_BW : SPAN_BW) + 1;

  localparam logic [CNT_BW-1:0] LOAD_LAST  = CNT_BW'(COL - 1);
  localparam logic [CNT_BW-1:0] GAP_LAST   = CNT_BW'(ROW - 1);
  localparam logic [CNT_BW-1:0] DRAIN_LAST = CNT_BW'(ROW + COL - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_GAP   = 3'd2,
    S_EXEC  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_BW-1:0]   cnt_q, cnt_d;
  logic [LEN_BW-1:0]   len_q, len_d;

  logic                busy_d, done_d, rd_en_d, sel_d;
  logic [ADDR_BW-1:0]  addr_d;
  logic [1:0]          base_inst;

  // State, counter and job-length registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Next-state logic; cnt restarts from zero on every state entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_BW'(1);
    len_d   = len_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start && (exec_len != '0)) begin
          state_d = S_LOAD;
          len_d   = exec_len;
        end
      end
      S_LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_EXEC;
          cnt_d   = '0;
        end
      end
      S_EXEC: begin
        if (cnt_q == (CNT_BW'(len_q) - CNT_BW'(1))) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore outputs for the coming cycle; address and region hold outside reads
  always_comb begin
    busy_d  = 1'b0;
    done_d  = 1'b0;
    rd_en_d = 1'b0;
    sel_d   = mem_sel;
    addr_d  = mem_addr;
    unique case (state_d)
      S_LOAD: begin
        busy_d  = 1'b1;
        rd_en_d = 1'b1;
        sel_d   = 1'b0;
        addr_d  = ADDR_BW'(cnt_d);
      end
      S_EXEC: begin
        busy_d  = 1'b1;
        rd_en_d = 1'b1;
        sel_d   = 1'b1;
        addr_d  = ADDR_BW'(cnt_d);
      end
      S_GAP, S_DRAIN: busy_d = 1'b1;
      S_DONE:         done_d = 1'b1;
      default: ;
    endcase
  end

  // Output registers; base_inst trails the read strobe to meet returning data
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_sel   <= 1'b0;
      mem_addr  <= '0;
      base_inst <= 2'b00;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      mem_rd_en <= rd_en_d;
      mem_sel   <= sel_d;
      mem_addr  <= addr_d;
      base_inst <= mem_rd_en ? (mem_sel ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  // Row r sees base_inst delayed by r cycles
  generate
    if (ROW > 1) begin : g_skew
      localparam int unsigned SKEW_W = 2 * (ROW - 1);
      logic [SKEW_W-1:0] skew_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          skew_q <= '0;
        end else begin
          skew_q <= SKEW_W'({skew_q, base_inst});
        end
      end

      assign inst_w = {skew_q, base_inst};
    end else begin : g_no_skew
      assign inst_w = base_inst;
    end
  endgenerate

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Randomized bench for mac_array_ctrl: two configurations checked every cycle
// against a timeline model derived from the job phase lengths.
module tb_mac_array_ctrl;

  localparam int AR  = 8;
  localparam int AC  = 8;
  localparam int BR  = 4;
  localparam int BC  = 2;
  localparam int BIG = 1 << 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset = 1'b1, a_start = 1'b0;
  logic [7:0]  a_len = 8'd0;
  logic        a_busy, a_done, a_rd, a_sel;
  logic [7:0]  a_addr;
  logic [15:0] a_inst;

  logic        b_reset = 1'b1, b_start = 1'b0;
  logic [7:0]  b_len = 8'd0;
  logic        b_busy, b_done, b_rd, b_sel;
  logic [7:0]  b_addr;
  logic [7:0]  b_inst;

  mac_array_ctrl #(.ROW(AR), .COL(AC), .LEN_BW(8), .ADDR_BW(8)) u_dut_a (
    .clk(clk), .reset(a_reset), .start(a_start), .exec_len(a_len),
    .busy(a_busy), .done(a_done), .mem_rd_en(a_rd), .mem_sel(a_sel),
    .mem_addr(a_addr), .inst_w(a_inst)
  );

  mac_array_ctrl #(.ROW(BR), .COL(BC), .LEN_BW(8), .ADDR_BW(8)) u_dut_b (
    .clk(clk), .reset(b_reset), .start(b_start), .exec_len(b_len),
    .busy(b_busy), .done(b_done), .mem_rd_en(b_rd), .mem_sel(b_sel),
    .mem_addr(b_addr), .inst_w(b_inst)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: t = cycles since the accepted start (BIG when no job is in flight)
  int         a_t = BIG, a_l = 0;
  logic       a_lsel = 1'b0;
  logic [7:0] a_laddr = 8'd0;
  int         b_t = BIG, b_l = 0;
  logic       b_lsel = 1'b0;
  logic [7:0] b_laddr = 8'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int t_done(input int r, input int c, input int l);
    return 2 * r + 2 * c + l + 1;
  endfunction

  function automatic logic rd_at(input int r, input int c, input int l, input int t);
    return ((t >= 1) && (t <= c)) || ((t >= c + r + 1) && (t <= c + r + l));
  endfunction

  // Instruction issued for the read made at job cycle u
  function automatic logic [1:0] lane_at(input int r, input int c, input int l, input int u);
    if ((u >= 1) && (u <= c)) return 2'b01;
    if ((u >= c + r + 1) && (u <= c + r + l)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_step(input string pfx, input int r, input int c, input int t, input int l,
                            input logic lsel, input logic [7:0] laddr,
                            input logic busy, input logic done, input logic rd, input logic sel,
                            input logic [7:0] addr, input logic [31:0] inst,
                            output logic n_sel, output logic [7:0] n_addr);
    logic        e_rd;
    logic [31:0] e_inst;
    int          td;
    td     = t_done(r, c, l);
    e_rd   = rd_at(r, c, l, t);
    n_sel  = e_rd ? (t > c) : lsel;
    n_addr = e_rd ? 8'((t > c) ? (t - c - r - 1) : (t - 1)) : laddr;
    e_inst = '0;
    for (int i = 0; i < r; i++) e_inst[2*i +: 2] = lane_at(r, c, l, t - i - 1);
    check({pfx, "_busy"}, 32'(busy), 32'((t >= 1) && (t < td)));
    check({pfx, "_done"}, 32'(done), 32'(t == td));
    check({pfx, "_rd_en"}, 32'(rd), 32'(e_rd));
    check({pfx, "_sel"}, 32'(sel), 32'(n_sel));
    check({pfx, "_addr"}, 32'(addr), 32'(n_addr));
    check({pfx, "_inst"}, inst, e_inst);
  endtask

  // Per-cycle compare, then advance the model with the inputs the next edge samples
  always @(negedge clk) begin : chk
    logic       ns;
    logic [7:0] na;
    model_step("a", AR, AC, a_t, a_l, a_lsel, a_laddr, a_busy, a_done, a_rd, a_sel,
               a_addr, 32'(a_inst), ns, na);
    a_lsel  <= a_reset ? 1'b0 : ns;
    a_laddr <= a_reset ? 8'd0 : na;
    if (a_reset) a_t <= BIG;
    else if ((a_t > t_done(AR, AC, a_l)) && a_start && (a_len != 8'd0)) begin
      a_t <= 1;
      a_l <= int'(a_len);
    end else if (a_t < BIG) a_t <= a_t + 1;

    model_step("b", BR, BC, b_t, b_l, b_lsel, b_laddr, b_busy, b_done, b_rd, b_sel,
               b_addr, 32'(b_inst), ns, na);
    b_lsel  <= b_reset ? 1'b0 : ns;
    b_laddr <= b_reset ? 8'd0 : na;
    if (b_reset) b_t <= BIG;
    else if ((b_t > t_done(BR, BC, b_l)) && b_start && (b_len != 8'd0)) begin
      b_t <= 1;
      b_l <= int'(b_len);
    end else if (b_t < BIG) b_t <= b_t + 1;
  end

  // One clock; start and reset are single-cycle pulses
  task automatic cyc();
    @(posedge clk);
    #1;
    a_start = 1'b0;
    a_reset = 1'b0;
    b_start = 1'b0;
    b_reset = 1'b0;
  endtask

  initial begin
    repeat (3) begin
      a_reset = 1'b1;
      b_reset = 1'b1;
      cyc();
    end
    repeat (2) cyc();

    // Job of 16 with stray starts at 5, 20, 49, then a second job at 50
    for (int c = 0; c <= 110; c++) begin
      if (c == 0 || c == 50) begin
        a_start = 1'b1;
        a_len   = 8'd16;
      end else if (c == 5 || c == 20 || c == 49) begin
        a_start = 1'b1;
        a_len   = 8'($urandom_range(1, 255));
      end
      cyc();
    end

    // Zero-length request is ignored, then a single-vector job
    a_start = 1'b1;
    a_len   = 8'd0;
    cyc();
    repeat (60) cyc();
    a_start = 1'b1;
    a_len   = 8'd1;
    cyc();
    repeat (40) cyc();

    // Reset in the middle of EXEC, then a fresh job
    a_start = 1'b1;
    a_len   = 8'd16;
    cyc();
    repeat (19) cyc();
    a_reset = 1'b1;
    cyc();
    repeat (10) cyc();
    a_start = 1'b1;
    a_len   = 8'($urandom_range(1, 64));
    cyc();
    repeat (110) cyc();

    // Small array: ROW=4, COL=2, three vectors
    b_start = 1'b1;
    b_len   = 8'd3;
    cyc();
    repeat (20) cyc();

    // Random jobs, stray starts and occasional resets on both arrays
    for (int j = 0; j < 25; j++) begin
      a_start = 1'b1;
      a_len   = 8'($urandom_range(1, 40));
      b_start = 1'b1;
      b_len   = 8'($urandom_range(1, 255));
      cyc();
      for (int c = 0; c < int'($urandom_range(20, 120)); c++) begin
        if ($urandom_range(0, 9) == 0) begin
          a_start = 1'b1;
          a_len   = 8'($urandom_range(0, 255));
        end
        if ($urandom_range(0, 9) == 0) begin
          b_start = 1'b1;
          b_len   = 8'($urandom_range(0, 255));
        end
        if ($urandom_range(0, 199) == 0) a_reset = 1'b1;
        if ($urandom_range(0, 199) == 0) b_reset = 1'b1;
        cyc();
      end
    end

    repeat (300) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_array_ctrl.md
Name: mac_array_ctrl

Overview:
- Sequencer for a ROW x COL systolic array of weight-stationary MAC tiles.
- Fetches one kernel load (weights) and then a stream of activation vectors from the shared input memory.
- Drives the per-row 2-bit instruction bus (bit1 = execute, bit0 = kernel load) with one cycle of skew per row.
- Waits for partial sums to drain out of the array, then reports completion through a start/busy/done handshake.

Parameters:
- ROW, 8, number of array rows; one inst_w lane per row.
- COL, 8, number of array columns; equals the kernel-load length in cycles.
- LEN_BW, 8, width of the exec_len configuration input.
- ADDR_BW, 8, width of the memory address output.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin; sampled only in IDLE
- exec_len  input  LEN_BW  number of activation vectors; latched when start is accepted
- busy  output  1  high while a job is in progress (LOAD through DRAIN)
- done  output  1  one-cycle completion pulse
- mem_rd_en  output  1  read strobe to the input memory; read data returns 1 cycle later
- mem_sel  output  1  0 = weight region, 1 = activation region
- mem_addr  output  ADDR_BW  read address within the selected region
- inst_w  output  2*ROW  row r instruction in bits [2r+1:2r]

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high.
- Reset values: state IDLE; busy, done, mem_rd_en, mem_sel = 0; mem_addr = 0; inst_w = 0; all counters and skew registers = 0.
- Reset mid-job: abandons the job. The next cycle shows all outputs at their reset values, with no done pulse.
- FSM states: IDLE, LOAD, GAP, EXEC, DRAIN, DONE. One counter (cnt) is cleared on every state entry.
- IDLE:
  - start=1 with exec_len != 0: latch exec_len into len_q and go to LOAD.
  - start=1 with exec_len == 0: ignored; stay in IDLE, no busy, no done.
- LOAD (COL cycles):
  - mem_rd_en=1, mem_sel=0, mem_addr=cnt (0..COL-1).
  - On cnt==COL-1, go to GAP.
- GAP (ROW cycles):
  - mem_rd_en=0. Lets the last weights reach the far columns and rows.
  - On cnt==ROW-1, go to EXEC.
- EXEC (len_q cycles):
  - mem_rd_en=1, mem_sel=1, mem_addr=cnt (0..len_q-1).
  - On cnt==len_q-1, go to DRAIN.
- DRAIN (ROW+COL cycles):
  - mem_rd_en=0. Lets psums finish propagating south.
  - On cnt==ROW+COL-1, go to DONE.
- DONE (1 cycle): done=1, busy=0, then IDLE. A start presented during DONE is ignored; start is accepted only in IDLE.
- busy is 1 exactly in LOAD, GAP, EXEC and DRAIN. Outputs are registered from the state and counters (Moore).
- mem_addr holds its last value when mem_rd_en=0. mem_addr and mem_sel change only in LOAD/EXEC; only mem_rd_en qualifies them.
- Instruction base:
  - base_inst is registered one cycle after mem_rd_en, so it aligns with the returning read data.
  - base_inst = 2'b01 for a LOAD read, 2'b10 for an EXEC read, and 2'b00 otherwise.
- Skew: row 0 lane = base_inst; row r lane = base_inst delayed r cycles through a ROW-1 deep shift register.
  - A job's instructions may still be flowing down the skew chain during DRAIN. That is intended; the chain is empty before DONE, since DRAIN (ROW+COL cycles) is longer than the skew depth (ROW-1) plus the 1-cycle base delay.
- Never asserted: inst_w 2'b11.
- Widths and wrap:
  - cnt is max(LEN_BW, clog2(ROW+COL))+1 bits; it never wraps within a state.
  - exec_len greater than 2^ADDR_BW is outside the supported range, and mem_addr truncates.
- Timing (start accepted at cycle 0, L = len_q):
  - LOAD: cycles 1..COL.
  - GAP: cycles COL+1..COL+ROW.
  - EXEC: cycles COL+ROW+1..COL+ROW+L.
  - DRAIN: the next ROW+COL cycles.
  - done: cycle 2*ROW + 2*COL + L + 1.

Test Plan:
- Defaults (ROW=COL=8), reset, start at cycle 0 with exec_len=16 -> busy=1 cycles 1-48; mem_rd_en=1 cycles 1-8 (sel 0, addr 0..7) and 17-32 (sel 1, addr 0..15); done=1 only at cycle 49; IDLE at cycle 50.
- Same run, inst_w check -> row 0 = 01 cycles 2-9 and 10 cycles 18-33; row 7 = 01 cycles 9-16 and 10 cycles 25-40; never 11; all lanes 0 from cycle 41.
- start with exec_len=0 -> busy, done and mem_rd_en stay 0 for 60 cycles. exec_len=1 -> single EXEC read at cycle 17 (addr 0), done at cycle 34.
- start pulsed again at cycles 5, 20 and 49 during the job -> ignored: only one done, timing identical to the first test. start at cycle 50 -> a second job whose done falls at cycle 99.
- reset asserted at cycle 20 (mid-EXEC) -> from cycle 21 all outputs 0, no done. A subsequent start runs a full, correct job.
- ROW=4, COL=2, exec_len=3 -> done at cycle 2*4 + 2*2 + 3 + 1 = 16; row 3 lane = 01 cycles 5-6 and 10 cycles 11-13.
